// File: rtl/lm_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : lm_port_arbiter
//  Description : Round-robin arbiter that shares port B of the compute group's
//                8K x 32 local RAM between cpu0, cpu1, the IO controller and
//                the global-memory transfer engine.
//                - The winning request is registered onto the RAM port.
//                - Read data is returned with a one-hot valid strobe.
//                - An exclusive mode reserves the port for the IO controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module lm_port_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
) (
  input  logic                  clock_50,
  input  logic                  reset,
  input  logic [3:0]            req,
  input  logic [3:0]            req_we,
  input  logic [4*ADDR_W-1:0]   req_addr,
  input  logic [4*DATA_W-1:0]   req_wdata,
  input  logic                  ioc_excl,
  output logic [3:0]            gnt,
  output logic [3:0]            rvalid,
  output logic [DATA_W-1:0]     rdata,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic                  ram_we,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic [DATA_W-1:0]     ram_q
);

  localparam int         c_NREQ     = 4;
  localparam logic [3:0] c_IOC_MASK = 4'b0100;

  // Registered state and its next-state values.
  logic [3:0]        gnt_q,       gnt_d;
  logic [3:0]        rd_tag_q,    rd_tag_d;    // read issued this cycle (aligned with gnt)
  logic [3:0]        rd_pend_q,   rd_pend_d;   // read whose data is on ram_q this cycle
  logic [3:0]        rvalid_q,    rvalid_d;
  logic [DATA_W-1:0] rdata_q,     rdata_d;
  logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
  logic              ram_we_q,    ram_we_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [1:0]        ptr_q,       ptr_d;

  // Per-requester views of the flattened request buses.
  logic [ADDR_W-1:0] w_addr  [c_NREQ];
  logic [DATA_W-1:0] w_wdata [c_NREQ];

  // Arbitration results.
  logic [3:0] w_elig;
  logic       w_found;
  logic [1:0] w_win;
  logic [1:0] w_idx;
  logic [3:0] w_win_oh;

  generate
    for (genvar gi = 0; gi < c_NREQ; gi++) begin : g_unpack
      assign w_addr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign w_wdata[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Eligible set: a requester granted this cycle is masked so its held
  // transaction is not granted twice; exclusive mode leaves only the IOC.
  always_comb begin
    w_elig = req & ~gnt_q;
    if (ioc_excl) begin
      w_elig = w_elig & c_IOC_MASK;
    end
  end

  // Round-robin search starting at ptr: first eligible index wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = 2'd0;
    w_idx   = 2'd0;
    for (int k = 0; k < c_NREQ; k++) begin
      w_idx = ptr_q + 2'(k);
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_win_oh = 4'b0001 << w_win;

  // Next-state: register the winner onto the RAM port and advance the
  // read-return pipeline. Address and write data hold when idle.
  always_comb begin
    gnt_d       = 4'b0000;
    ram_we_d    = 1'b0;
    rd_tag_d    = 4'b0000;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ptr_d       = ptr_q;
    rd_pend_d   = rd_tag_q;
    rvalid_d    = rd_pend_q;
    rdata_d     = ram_q;
    if (w_found) begin
      gnt_d       = w_win_oh;
      ram_addr_d  = w_addr[w_win];
      ram_we_d    = req_we[w_win];
      ram_wdata_d = w_wdata[w_win];
      rd_tag_d    = req_we[w_win] ? 4'b0000 : w_win_oh;
      ptr_d       = w_win + 2'd1;
    end
  end

  // State register with synchronous reset; reset also flushes any
  // in-flight read so it produces no rvalid.
  always_ff @(posedge clock_50) begin
    if (reset) begin
      gnt_q       <= '0;
      rd_tag_q    <= '0;
      rd_pend_q   <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      ptr_q       <= 2'd0;
    end else begin
      gnt_q       <= gnt_d;
      rd_tag_q    <= rd_tag_d;
      rd_pend_q   <= rd_pend_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      ptr_q       <= ptr_d;
    end
  end

  assign gnt       = gnt_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_lm_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lm_port_arbiter
//  Description : Directed self-checking bench for lm_port_arbiter with a
//                behavioural new-data read-during-write RAM on port B.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lm_port_arbiter;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;

  logic                clock_50;
  logic                reset;
  logic [3:0]          req;
  logic [3:0]          req_we;
  logic [4*ADDR_W-1:0] req_addr;
  logic [4*DATA_W-1:0] req_wdata;
  logic                ioc_excl;
  logic [3:0]          gnt;
  logic [3:0]          rvalid;
  logic [DATA_W-1:0]   rdata;
  logic [ADDR_W-1:0]   ram_addr;
  logic                ram_we;
  logic [DATA_W-1:0]   ram_wdata;
  logic [DATA_W-1:0]   ram_q;

  // RAM model state and preload port.
  logic [DATA_W-1:0]   mem [0:8191];
  logic                pre_en;
  logic [ADDR_W-1:0]   pre_addr;
  logic [DATA_W-1:0]   pre_data;

  int n_checks = 0;
  int n_fail   = 0;

  lm_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock_50  (clock_50),
    .reset     (reset),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .ioc_excl  (ioc_excl),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_q     (ram_q)
  );

  initial clock_50 = 1'b0;
  always #5 clock_50 = ~clock_50;

  // Port B of the RAM macro: one-cycle read latency, new data on read-during-write.
  always @(posedge clock_50) begin
    if (pre_en) begin
      mem[pre_addr] <= pre_data;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_q <= ram_we ? ram_wdata : mem[ram_addr];
  end

  task automatic tick();
    @(posedge clock_50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic set_req(input int i, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    req[i]                      = 1'b1;
    req_we[i]                   = we;
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    pre_en   = 1'b1;
    pre_addr = a;
    pre_data = d;
    tick();
  endtask

  // Expected sequences for the contention and exclusive-mode phases.
  logic [3:0]        e_cg  [7] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h0, 4'h0};
  logic [3:0]        e_crv [7] = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
  logic [DATA_W-1:0] e_crd [7] = '{32'h0, 32'h0, 32'hA0000000, 32'hA0000001,
                                   32'hA0000002, 32'hA0000003, 32'hA0000000};
  logic [ADDR_W-1:0] e_cad [7] = '{13'h100, 13'h101, 13'h102, 13'h103,
                                   13'h100, 13'h100, 13'h100};
  logic [3:0]        e_xg  [8] = '{4'h4, 4'h0, 4'h4, 4'h0, 4'h1, 4'h2, 4'h0, 4'h0};
  logic [3:0]        e_xrv [8] = '{4'h0, 4'h0, 4'h4, 4'h0, 4'h4, 4'h0, 4'h1, 4'h2};
  logic [DATA_W-1:0] e_xrd [8] = '{32'h0, 32'h0, 32'hA0000002, 32'h0,
                                   32'hA0000002, 32'h0, 32'hDEADBEEF, 32'hA0000001};

  initial begin
    reset     = 1'b1;
    req       = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    ioc_excl  = 1'b0;
    pre_en    = 1'b0;
    pre_addr  = '0;
    pre_data  = '0;

    // Preload RAM while reset is held.
    preload(13'h0010, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) preload(13'h0100 + 13'(i), 32'hA0000000 + 32'(i));
    pre_en = 1'b0;
    tick();

    // Reset values.
    chk("rst_gnt",   gnt,       4'h0);
    chk("rst_rvld",  rvalid,    4'h0);
    chk("rst_rdata", rdata,     32'h0);
    chk("rst_addr",  ram_addr,  13'h0);
    chk("rst_we",    ram_we,    1'b0);
    chk("rst_wdata", ram_wdata, 32'h0);

    // Single read by cpu0; first edge after reset falls may grant.
    reset = 1'b0;
    set_req(0, 1'b0, 13'h0010, 32'h0);
    tick();
    chk("rd_gnt",  gnt,      4'h1);
    chk("rd_addr", ram_addr, 13'h0010);
    chk("rd_we",   ram_we,   1'b0);
    chk("rd_rv1",  rvalid,   4'h0);
    req[0] = 1'b0;
    tick();
    chk("rd_gnt2", gnt,    4'h0);
    chk("rd_rv2",  rvalid, 4'h0);
    tick();
    chk("rd_rv3",   rvalid, 4'h1);
    chk("rd_data",  rdata,  32'hDEADBEEF);
    tick();
    chk("rd_rv4",  rvalid, 4'h0);

    // IOC write then immediate read of the same address.
    set_req(2, 1'b1, 13'h1FFF, 32'h12345678);
    tick();
    chk("wr_gnt",   gnt,       4'h4);
    chk("wr_we",    ram_we,    1'b1);
    chk("wr_addr",  ram_addr,  13'h1FFF);
    chk("wr_wdata", ram_wdata, 32'h12345678);
    set_req(2, 1'b0, 13'h1FFF, 32'h0);
    tick();
    chk("wr_gap_gnt",  gnt,      4'h0);
    chk("wr_gap_we",   ram_we,   1'b0);
    chk("wr_gap_addr", ram_addr, 13'h1FFF);
    tick();
    chk("wr_rd_gnt", gnt,    4'h4);
    chk("wr_rd_we",  ram_we, 1'b0);
    chk("wr_rv_a",   rvalid, 4'h0);
    req[2] = 1'b0;
    tick();
    chk("wr_rv_b", rvalid, 4'h0);
    tick();
    chk("wr_rv_c",   rvalid, 4'h4);
    chk("wr_rdata",  rdata,  32'h12345678);
    tick();
    chk("wr_rv_d", rvalid, 4'h0);

    // Contention: all four request continuously from ptr=0.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 13'h0100 + 13'(i), 32'h0);
    for (int k = 0; k < 7; k++) begin
      tick();
      chk($sformatf("ct_gnt%0d", k),  gnt,      e_cg[k]);
      chk($sformatf("ct_rv%0d", k),   rvalid,   e_crv[k]);
      chk($sformatf("ct_addr%0d", k), ram_addr, e_cad[k]);
      if (e_crv[k] != 4'h0) chk($sformatf("ct_rd%0d", k), rdata, e_crd[k]);
      if (k == 4) req = 4'h0;
    end

    // Exclusive mode: only the IOC is granted, then cpu0/cpu1 in ptr order.
    ioc_excl = 1'b1;
    set_req(0, 1'b0, 13'h0010, 32'h0);
    set_req(1, 1'b0, 13'h0101, 32'h0);
    set_req(2, 1'b0, 13'h0102, 32'h0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("ex_gnt%0d", k), gnt,    e_xg[k]);
      chk($sformatf("ex_rv%0d", k),  rvalid, e_xrv[k]);
      if (e_xrv[k] != 4'h0) chk($sformatf("ex_rd%0d", k), rdata, e_xrd[k]);
      if (k == 2) req[2]   = 1'b0;
      if (k == 3) ioc_excl = 1'b0;
      if (k == 4) req[0]   = 1'b0;
      if (k == 5) req[1]   = 1'b0;
    end

    // Reset in the cycle where the cpu1 read data sits on ram_q.
    set_req(1, 1'b0, 13'h0101, 32'h0);
    tick();
    chk("mr_gnt", gnt, 4'h2);
    req[1] = 1'b0;
    tick();
    chk("mr_gnt2", gnt, 4'h0);
    reset = 1'b1;
    tick();
    chk("mr_gnt0",   gnt,       4'h0);
    chk("mr_rv0",    rvalid,    4'h0);
    chk("mr_rdata0", rdata,     32'h0);
    chk("mr_addr0",  ram_addr,  13'h0);
    chk("mr_we0",    ram_we,    1'b0);
    chk("mr_wdata0", ram_wdata, 32'h0);
    reset = 1'b0;
    set_req(0, 1'b0, 13'h0010, 32'h0);
    set_req(2, 1'b0, 13'h0103, 32'hCAFE0003);
    tick();
    chk("mr_ptr_gnt", gnt,    4'h1);
    chk("mr_rv1",     rvalid, 4'h0);
    req[0] = 1'b0;
    tick();
    chk("mr_gnt_ioc", gnt,    4'h4);
    chk("mr_rv2",     rvalid, 4'h0);
    req[2] = 1'b0;
    tick();
    chk("mr_rv3",  rvalid, 4'h1);
    chk("mr_rd3",  rdata,  32'hDEADBEEF);
    tick();
    chk("mr_rv4",  rvalid, 4'h4);
    chk("mr_rd4",  rdata,  32'hA0000003);

    // Idle: outputs quiet, address and write data hold.
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("idle_gnt%0d", k),   gnt,       4'h0);
      chk($sformatf("idle_we%0d", k),    ram_we,    1'b0);
      chk($sformatf("idle_rv%0d", k),    rvalid,    4'h0);
      chk($sformatf("idle_addr%0d", k),  ram_addr,  13'h0103);
      chk($sformatf("idle_wdata%0d", k), ram_wdata, 32'hCAFE0003);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
